delay_loop_monitor: RTL and testbench
=====================================

Name: delay_loop_monitor

Overview:
- Sequential launch/capture monitor for the fixed both-edge delay cells; the measuring end of the delay path.
- Drives a launch edge into a delay cell input and receives the cell output asynchronously.
- Counts clock cycles until each edge returns, measuring the rising and falling edges separately.
- Reports both counts, an error code and a pass flag against a programmable window; used by stepdown/core-state bring-up to confirm delay cells are alive and in range.

Parameters:
- CNT_W, 8, width of counters and result outputs.
- TIMEOUT, 200, cycle limit for each settle or wait phase; must be < 2^CNT_W.
- SYNC_STAGES, 2, synchroniser depth on ret; legal range 2..3.

Ports:
- CELCLK  in  1  clock.
- CELRSTN  in  1  asynchronous active-low reset.
- CELV  in  1  supply pin; no logic function.
- CELG  in  1  ground pin; no logic function.
- CELSUB  in  1  substrate pin; no logic function.
- start  in  1  one-cycle request to begin a measurement; sampled only in IDLE.
- lo_lim  in  CNT_W  minimum acceptable count, inclusive; sampled at start.
- hi_lim  in  CNT_W  maximum acceptable count, inclusive; sampled at start.
- ret  in  1  asynchronous delay-cell output; synchronised internally.
- launch  out  1  registered drive to the delay-cell input.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- rise_cnt  out  CNT_W  measured rising-edge count.
- fall_cnt  out  CNT_W  measured falling-edge count.
- err  out  2  0 = ok, 1 = settle timeout, 2 = rise timeout, 3 = fall timeout.
- pass  out  1  high when err = 0 and both counts are within [lo_lim, hi_lim].

Behaviour:
- Reset (async assert, sync release): launch = 0, busy = 0, done = 0, rise_cnt = 0, fall_cnt = 0, err = 0, pass = 0, state = IDLE, counter = 0, synchroniser flops = 0.
- rs is the SYNC_STAGES-deep synchronised copy of ret; all decisions use rs only.
- IDLE: on start = 1, latch lo_lim and hi_lim, clear counter, go to SETTLE; busy rises the next cycle. While busy, start is ignored.
- SETTLE: launch = 0. If rs = 0, go to LAUNCH_R. Otherwise increment the counter; when the counter reaches TIMEOUT-1 with rs still 1, set err = 1 and go to DONE.
- LAUNCH_R: set launch = 1, clear counter, go to WAIT_R.
- WAIT_R: each cycle rs = 0, increment counter. On the first cycle rs = 1, capture counter into rise_cnt and go to LAUNCH_F. If the counter reaches TIMEOUT-1 first, set err = 2, set rise_cnt = TIMEOUT-1, and go to DONE.
- LAUNCH_F / WAIT_F: mirror of the rise path. launch = 0, wait for rs = 0, capture into fall_cnt. On timeout, err = 3 and fall_cnt = TIMEOUT-1.
- DONE: one cycle. done = 1, busy falls the same cycle, pass is computed, then return to IDLE.
- Count meaning: zero-delay loopback (ret = launch) gives a count of exactly SYNC_STAGES. A synchronous delay of D cycles gives SYNC_STAGES + D.
- On any error, launch returns to 0 in DONE. An error reported in SETTLE leaves both counts at 0.
- Results, err and pass hold until the next accepted start. At start they are cleared to 0 in the cycle busy rises.
- A ret glitch shorter than one clock period may be missed; this is acceptable, as the monitor measures only stable edges.
- Reset mid-measurement immediately drops launch and busy; no done pulse is produced.
- The counter never wraps because it is bounded by TIMEOUT-1.
- Window compare is unsigned; lo_lim > hi_lim forces pass = 0.

Test Plan:
- Loopback ret = launch, lo_lim = 1, hi_lim = 4, start pulse -> rise_cnt = 2, fall_cnt = 2, err = 0, pass = 1, done one cycle, busy falls with done.
- ret = launch delayed by 5 clocks, window 6..8 -> rise_cnt = 7, fall_cnt = 7, pass = 1; repeat with window 0..6 -> pass = 0, err = 0.
- Rise delay 3 clocks, fall delay 10 clocks -> rise_cnt = 5, fall_cnt = 12; check that the two counts are independent.
- ret stuck 0 -> err = 2, rise_cnt = 199, pass = 0, launch = 0 after done. ret stuck 1 -> err = 1 after 199 SETTLE cycles, counts = 0.
- start pulses during busy -> no restart and exactly one done. Second start after done -> outputs clear, then new results.
- CELRSTN asserted in WAIT_R -> launch, busy and outputs drop asynchronously. Start after release -> normal loopback result of 2/2.

Source files
------------

// File: rtl/delay_loop_monitor.sv
// rtl/delay_loop_monitor.sv - launch/capture monitor measuring rise and fall delay of a delay cell
`timescale 1ns/1ps
module delay_loop_monitor #(
   parameter int CNT_W       = 8,
   parameter int TIMEOUT     = 200,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CELCLK,
   input  logic             CELRSTN,
   input  logic             CELV,
   input  logic             CELG,
   input  logic             CELSUB,
   input  logic             start,
   input  logic [CNT_W-1:0] lo_lim,
   input  logic [CNT_W-1:0] hi_lim,
   input  logic             ret,
   output logic             launch,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] fall_cnt,
   output logic [1:0]       err,
   output logic             pass
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_LAUNCH_R,
      S_WAIT_R,
      S_LAUNCH_F,
      S_WAIT_F,
      S_DONE
   } state_t;

   // Last counter value that can still advance; the next step would reach TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_SETTLE = 2'd1;
   localparam logic [1:0] ERR_RISE   = 2'd2;
   localparam logic [1:0] ERR_FALL   = 2'd3;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   launch_q, launch_d;
   logic [CNT_W-1:0]       rise_q, rise_d;
   logic [CNT_W-1:0]       fall_q, fall_d;
   logic [1:0]             err_q, err_d;
   logic                   pass_q, pass_d;
   logic [CNT_W-1:0]       lo_q, lo_d;
   logic [CNT_W-1:0]       hi_q, hi_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rs;
   logic                   win_ok;

   // Supply, ground and substrate pins carry no logic function.
   logic unused_pins;
   assign unused_pins = CELV ^ CELG ^ CELSUB;

   assign rs = sync_q[SYNC_STAGES-1];

   // Synchronise the asynchronous delay-cell return into the clock domain.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ret};
      end
   end

   // Window check on the values being written as the measurement completes.
   assign win_ok = (err_d == ERR_OK) &&
                   (lo_q <= rise_d) && (rise_d <= hi_q) &&
                   (lo_q <= fall_d) && (fall_d <= hi_q);

   // Next-state and result logic for the launch/capture sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      launch_d = launch_q;
      rise_d   = rise_q;
      fall_d   = fall_q;
      err_d    = err_q;
      pass_d   = pass_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lo_d    = lo_lim;
               hi_d    = hi_lim;
               cnt_d   = '0;
               rise_d  = '0;
               fall_d  = '0;
               err_d   = ERR_OK;
               pass_d  = 1'b0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            launch_d = 1'b0;
            if (!rs) begin
               state_d = S_LAUNCH_R;
            end else if (cnt_q >= CNT_PRE) begin
               cnt_d   = CNT_LAST;
               err_d   = ERR_SETTLE;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LAUNCH_R: begin
            launch_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (rs) begin
               rise_d  = cnt_q;
               state_d = S_LAUNCH_F;
            end else if (cnt_q >= CNT_PRE) begin
               cnt_d   = CNT_LAST;
               rise_d  = CNT_LAST;
               err_d   = ERR_RISE;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LAUNCH_F: begin
            launch_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_WAIT_F;
         end
         S_WAIT_F: begin
            if (!rs) begin
               fall_d  = cnt_q;
               state_d = S_DONE;
            end else if (cnt_q >= CNT_PRE) begin
               cnt_d   = CNT_LAST;
               fall_d  = CNT_LAST;
               err_d   = ERR_FALL;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Entering DONE always parks the launch low and settles the verdict.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         launch_d = 1'b0;
         pass_d   = win_ok;
      end
   end

   // State, counter and result registers.
   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         launch_q <= 1'b0;
         rise_q   <= '0;
         fall_q   <= '0;
         err_q    <= ERR_OK;
         pass_q   <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         launch_q <= launch_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   assign launch   = launch_q;
   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign rise_cnt = rise_q;
   assign fall_cnt = fall_q;
   assign err      = err_q;
   assign pass     = pass_q;

endmodule

// File: tb/tb_delay_loop_monitor.sv
// tb/tb_delay_loop_monitor.sv - self-checking bench for delay_loop_monitor
`timescale 1ns/1ps
module tb_delay_loop_monitor;

   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 200;
   localparam int SS      = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] lo = '0;
   logic [CNT_W-1:0] hi = '0;
   logic             ret;
   logic             launch, busy, done, pass;
   logic [CNT_W-1:0] rise_cnt, fall_cnt;
   logic [1:0]       err;

   int checks = 0;
   int failures = 0;

   // ret shaping: mode 0 = delayed copy of launch, 1 = stuck 0, 2 = stuck 1
   int          cfg_dr = 0;
   int          cfg_df = 0;
   int          cfg_mode = 0;
   logic [63:0] hq = '0;
   logic        model_ret;

   always #5 clk = ~clk;

   // hq[k] is launch as it was k+1 clock cycles ago
   always @(posedge clk) hq <= {hq[62:0], launch};

   // ret rises once launch has been high for cfg_dr cycles and falls cfg_df cycles after launch drops
   always_comb begin
      logic all1;
      logic any1;
      all1 = launch;
      for (int k = 0; k < cfg_dr; k++) if (!hq[k]) all1 = 1'b0;
      any1 = 1'b0;
      for (int k = 0; k < cfg_df; k++) if (hq[k]) any1 = 1'b1;
      model_ret = launch ? all1 : any1;
   end

   assign ret = (cfg_mode == 1) ? 1'b0 : (cfg_mode == 2) ? 1'b1 : model_ret;

   delay_loop_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SS)) dut (
      .CELCLK  (clk),
      .CELRSTN (rstn),
      .CELV    (1'b1),
      .CELG    (1'b0),
      .CELSUB  (1'b0),
      .start   (start),
      .lo_lim  (lo),
      .hi_lim  (hi),
      .ret     (ret),
      .launch  (launch),
      .busy    (busy),
      .done    (done),
      .rise_cnt(rise_cnt),
      .fall_cnt(fall_cnt),
      .err     (err),
      .pass    (pass)
   );

   typedef struct {
      int rise;
      int fall;
      int err;
      int pass;
   } res_t;

   typedef struct {
      string name;
      int    dr;
      int    df;
      int    mode;
      int    lo;
      int    hi;
      int    lat;
      res_t  exp;
   } vec_t;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Expected outcome straight from the measurement rules: count = sync depth + cell delay.
   function automatic res_t model(input int dr, input int df, input int mode, input int lo_v, input int hi_v);
      res_t m;
      int   maxc;
      maxc   = TIMEOUT - 2;
      m.rise = 0;
      m.fall = 0;
      m.err  = 0;
      if (mode == 2) begin
         m.err = 1;
      end else if (mode == 1) begin
         m.err  = 2;
         m.rise = TIMEOUT - 1;
      end else begin
         m.rise = SS + dr;
         if (m.rise > maxc) begin
            m.err  = 2;
            m.rise = TIMEOUT - 1;
         end else begin
            m.fall = SS + df;
            if (m.fall > maxc) begin
               m.err  = 3;
               m.fall = TIMEOUT - 1;
            end
         end
      end
      m.pass = (m.err == 0 && lo_v <= m.rise && m.rise <= hi_v &&
                lo_v <= m.fall && m.fall <= hi_v) ? 1 : 0;
      return m;
   endfunction

   task automatic measure(input string name, input int dr, input int df, input int mode,
                          input int lo_v, input int hi_v, input int exp_lat, input res_t e);
      int lat;
      cfg_dr   = dr;
      cfg_df   = df;
      cfg_mode = mode;
      repeat (50) @(negedge clk);
      lo    = CNT_W'(lo_v);
      hi    = CNT_W'(hi_v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy_rise"}, int'(busy), 1);
      check({name, "_clear"}, int'(rise_cnt) + int'(fall_cnt) + int'(err) + int'(pass), 0);
      lat = 0;
      while (!done && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         check({name, "_done_timeout"}, 0, 1);
      end else begin
         if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
         check({name, "_busy_at_done"}, int'(busy), 0);
         check({name, "_launch_at_done"}, int'(launch), 0);
         check({name, "_rise"}, int'(rise_cnt), e.rise);
         check({name, "_fall"}, int'(fall_cnt), e.fall);
         check({name, "_err"}, int'(err), e.err);
         check({name, "_pass"}, int'(pass), e.pass);
         @(negedge clk);
         check({name, "_done_one_cycle"}, int'(done), 0);
         check({name, "_hold_rise"}, int'(rise_cnt), e.rise);
         check({name, "_hold_pass"}, int'(pass), e.pass);
      end
   endtask

   vec_t tbl[9];

   initial begin
      res_t e;
      int   dcount;
      int   cyc;
      int   dr, df, lv, hv;

      tbl[0] = '{"loopback",  0,  0, 0, 1,   4,  -1, '{2,   2,   0, 1}};
      tbl[1] = '{"d5_win6_8", 5,  5, 0, 6,   8,  -1, '{7,   7,   0, 1}};
      tbl[2] = '{"d5_win0_6", 5,  5, 0, 0,   6,  -1, '{7,   7,   0, 0}};
      tbl[3] = '{"r3_f10",    3, 10, 0, 0, 255,  -1, '{5,  12,   0, 1}};
      tbl[4] = '{"r3_f10_hi", 3, 10, 0, 5,  11,  -1, '{5,  12,   0, 0}};
      tbl[5] = '{"stuck0",    0,  0, 1, 0, 255,  -1, '{199, 0,   2, 0}};
      tbl[6] = '{"stuck1",    0,  0, 2, 0, 255, 199, '{0,   0,   1, 0}};
      tbl[7] = '{"lo_gt_hi",  0,  0, 0, 5,   1,  -1, '{2,   2,   0, 0}};
      tbl[8] = '{"win_exact", 0,  0, 0, 2,   2,  -1, '{2,   2,   0, 1}};

      repeat (3) @(negedge clk);
      check("reset_outputs", int'(launch) + int'(busy) + int'(done) + int'(rise_cnt) +
            int'(fall_cnt) + int'(err) + int'(pass), 0);
      rstn = 1'b1;
      @(negedge clk);
      check("post_reset_idle", int'(launch) + int'(busy) + int'(done) + int'(pass), 0);

      foreach (tbl[i])
         measure(tbl[i].name, tbl[i].dr, tbl[i].df, tbl[i].mode, tbl[i].lo, tbl[i].hi,
                 tbl[i].lat, tbl[i].exp);

      for (int n = 0; n < 12; n++) begin
         dr = $urandom_range(0, 20);
         df = $urandom_range(0, 20);
         lv = $urandom_range(0, 25);
         hv = $urandom_range(0, 25);
         e  = model(dr, df, 0, lv, hv);
         measure($sformatf("rand%0d_r%0d_f%0d", n, dr, df), dr, df, 0, lv, hv, -1, e);
      end

      // start pulses while busy must neither restart nor add done pulses
      cfg_dr = 5;
      cfg_df = 5;
      cfg_mode = 0;
      repeat (50) @(negedge clk);
      lo = 8'd0;
      hi = 8'd20;
      start = 1'b1;
      @(negedge clk);
      dcount = 0;
      cyc = 0;
      while (cyc < 1000 && dcount == 0) begin
         start = ((cyc % 3) == 1) ? 1'b1 : 1'b0;
         @(negedge clk);
         cyc++;
         if (done) dcount++;
      end
      start = 1'b0;
      check("busy_start_rise", int'(rise_cnt), 7);
      check("busy_start_fall", int'(fall_cnt), 7);
      repeat (60) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("busy_start_done_count", dcount, 1);
      check("busy_start_idle", int'(busy), 0);

      // reset while waiting for the rising edge
      cfg_dr = 8;
      cfg_df = 0;
      repeat (50) @(negedge clk);
      lo = 8'd1;
      hi = 8'd20;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!launch && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("midrst_launch_seen", int'(launch), 1);
      check("midrst_busy_before", int'(busy), 1);
      #2 rstn = 1'b0;
      #1;
      check("midrst_launch_drop", int'(launch), 0);
      check("midrst_busy_drop", int'(busy), 0);
      check("midrst_outputs_zero", int'(done) + int'(rise_cnt) + int'(fall_cnt) +
            int'(err) + int'(pass), 0);
      @(negedge clk);
      rstn = 1'b1;
      e = '{2, 2, 0, 1};
      measure("after_reset_loopback", 0, 0, 0, 1, 4, -1, e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
